// File: rtl/garduino_sys_v1_actuators.sv
`default_nettype none
// ============================================================================
// Module      : garduino_sys_v1_actuators
// Description : Avalon-MM actuator output port with SET/CLR access and a
//               watchdog that forces masked outputs off when not refreshed.
// Revision    : 1.0
// ============================================================================
module garduino_sys_v1_actuators #(
    parameter int              WIDTH    = 8,
    parameter int              TICK_DIV = 50000,
    parameter int              TMO_W    = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PS_W-1:0]  c_ps_last  = PS_W'(TICK_DIV - 1);
    localparam logic [PS_W-1:0]  c_ps_one   = PS_W'(1);
    localparam logic [TMO_W-1:0] c_cnt_one  = TMO_W'(1);

    localparam logic [2:0] c_addr_data    = 3'd0;
    localparam logic [2:0] c_addr_set     = 3'd1;
    localparam logic [2:0] c_addr_clr     = 3'd2;
    localparam logic [2:0] c_addr_timeout = 3'd3;
    localparam logic [2:0] c_addr_kick    = 3'd4;
    localparam logic [2:0] c_addr_status  = 3'd5;
    localparam logic [2:0] c_addr_mask    = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_out, w_out_nxt;
    logic [WIDTH-1:0]   r_mask, w_mask_nxt;
    logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;
    logic [TMO_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_timed_out, w_timed_out_nxt;
    logic [PS_W-1:0]    r_ps;
    logic [31:0]        r_rdata, w_rdata;
    logic               w_write;
    logic               w_kick;
    logic               w_tick;

    assign w_write  = chipselect & ~write_n;
    assign w_kick   = w_write & (address <= c_addr_kick);
    assign w_tick   = (r_ps == c_ps_last);

    assign readdata = r_rdata;
    assign out_port = r_out;
    assign irq      = r_timed_out;

    // Free-running tick prescaler; kicks deliberately leave it alone.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ps <= '0;
        end else if (w_tick) begin
            r_ps <= '0;
        end else begin
            r_ps <= r_ps + c_ps_one;
        end
    end

    // Read mux samples the pre-write register state.
    always_comb begin
        w_rdata = '0;
        case (address)
            c_addr_data,
            c_addr_set,
            c_addr_clr:     w_rdata[WIDTH-1:0] = r_out;
            c_addr_timeout: w_rdata[TMO_W-1:0] = r_tmo;
            c_addr_kick:    w_rdata[TMO_W-1:0] = r_cnt;
            c_addr_status:  w_rdata[0]         = r_timed_out;
            c_addr_mask:    w_rdata[WIDTH-1:0] = r_mask;
            default:        w_rdata            = '0;
        endcase
    end

    always_comb begin
        w_out_nxt       = r_out;
        w_mask_nxt      = r_mask;
        w_tmo_nxt       = r_tmo;
        w_cnt_nxt       = r_cnt;
        w_timed_out_nxt = r_timed_out;
        w_state_nxt     = r_state;

        if (w_write) begin
            case (address)
                c_addr_data:    w_out_nxt  = writedata[WIDTH-1:0];
                c_addr_set:     w_out_nxt  = r_out | writedata[WIDTH-1:0];
                c_addr_clr:     w_out_nxt  = r_out & ~writedata[WIDTH-1:0];
                c_addr_timeout: w_tmo_nxt  = writedata[TMO_W-1:0];
                c_addr_status:  if (writedata[0]) w_timed_out_nxt = 1'b0;
                c_addr_mask:    w_mask_nxt = writedata[WIDTH-1:0];
                default:        ;
            endcase
        end

        // A kick always beats an expiring tick; expiry never overlaps an out write.
        if (w_kick) begin
            w_cnt_nxt = w_tmo_nxt;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_tick) begin
                        if (r_cnt == c_cnt_one) begin
                            w_out_nxt       = r_out & ~r_mask;
                            w_timed_out_nxt = 1'b1;
                        end
                        w_cnt_nxt = r_cnt - c_cnt_one;
                    end
                end
                default: w_cnt_nxt = '0;
            endcase
        end

        if (w_tmo_nxt == '0) begin
            w_cnt_nxt = '0;
        end

        w_state_nxt = (w_cnt_nxt != '0) ? S_RUN : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_out       <= RST_VAL;
            r_mask      <= '0;
            r_tmo       <= '0;
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out       <= w_out_nxt;
            r_mask      <= w_mask_nxt;
            r_tmo       <= w_tmo_nxt;
            r_cnt       <= w_cnt_nxt;
            r_timed_out <= w_timed_out_nxt;
            r_rdata     <= w_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_garduino_sys_v1_actuators.sv
`default_nettype none
// ============================================================================
// Module      : tb_garduino_sys_v1_actuators
// Description : Randomized and directed self-checking bench for the actuator port.
// Revision    : 1.0
// ============================================================================
module tb_garduino_sys_v1_actuators;

    localparam int WIDTH = 8;
    localparam int TD    = 4;
    localparam int TMO_W = 16;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        irq;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state (plain integers, updated once per rising edge)
    int unsigned m_out, m_mask, m_tmo, m_cnt, m_ps, m_to, m_rd;

    garduino_sys_v1_actuators #(
        .WIDTH   (WIDTH),
        .TICK_DIV(TD),
        .TMO_W   (TMO_W),
        .RST_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned m_read(input int unsigned a);
        case (a)
            0, 1, 2: return m_out;
            3:       return m_tmo;
            4:       return m_cnt;
            5:       return m_to;
            6:       return m_mask;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input logic rn, input logic cs, input logic wn,
                              input logic [2:0] a, input logic [31:0] wd);
        int unsigned n_out, n_mask, n_tmo, n_cnt, n_to, d;
        bit we, kick, tick;
        if (!rn) begin
            m_out = 0; m_mask = 0; m_tmo = 0; m_cnt = 0;
            m_ps = 0; m_to = 0; m_rd = 0;
            return;
        end
        we   = cs && !wn;
        kick = we && (a <= 3'd4);
        tick = (m_ps == TD - 1);
        d    = wd;
        n_out = m_out; n_mask = m_mask; n_tmo = m_tmo; n_to = m_to; n_cnt = m_cnt;
        if (we) begin
            case (a)
                3'd0: n_out  = d & 32'hFF;
                3'd1: n_out  = (m_out | d) & 32'hFF;
                3'd2: n_out  = m_out & ~d & 32'hFF;
                3'd3: n_tmo  = d & 32'hFFFF;
                3'd5: if (d[0]) n_to = 0;
                3'd6: n_mask = d & 32'hFF;
                default: ;
            endcase
        end
        if (kick) begin
            n_cnt = n_tmo;
        end else if (tick && m_cnt > 0) begin
            if (m_cnt == 1) begin
                n_out = m_out & ~m_mask & 32'hFF;
                n_to  = 1;
            end
            n_cnt = m_cnt - 1;
        end
        m_rd   = m_read(a);
        m_ps   = tick ? 0 : m_ps + 1;
        m_out  = n_out; m_mask = n_mask; m_tmo = n_tmo;
        m_cnt  = n_cnt; m_to = n_to;
    endtask

    // One clock: drive inputs, advance model at the edge, settle past the edge.
    task automatic cycle(input logic rn, input logic cs, input logic wn,
                         input logic [2:0] a, input logic [31:0] wd);
        reset_n    = rn;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        @(posedge clk);
        model_step(rn, cs, wn, a, wd);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        cycle(1'b1, 1'b1, 1'b0, a, wd);
    endtask

    task automatic idle(input logic [2:0] a);
        cycle(1'b1, 1'b0, 1'b1, a, 32'h0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_port !== 8'h00) begin n_err++; $display("FAIL reset_out: got %h want 00", out_port); end
        n_checks++;
        if (readdata !== 32'h0) begin n_err++; $display("FAIL reset_readdata: got %h want 0", readdata); end
        n_checks++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
        wr(3'd7, 32'hFFFF_FFFF);
        idle(3'd7);
        n_checks++;
        if (readdata !== 32'h0) begin n_err++; $display("FAIL addr7_read: got %h want 0", readdata); end
        n_checks++;
        if (out_port !== 8'h00) begin n_err++; $display("FAIL addr7_write_ignored: got %h want 00", out_port); end
    endtask

    task automatic test_bit_ops();
        wr(3'd0, 32'h0000_00A5);
        n_checks++;
        if (out_port !== 8'hA5) begin n_err++; $display("FAIL bitops_data: got %h want A5", out_port); end
        wr(3'd1, 32'h0000_000F);
        n_checks++;
        if (out_port !== 8'hAF) begin n_err++; $display("FAIL bitops_set: got %h want AF", out_port); end
        wr(3'd2, 32'h0000_0003);
        n_checks++;
        if (out_port !== 8'hAC) begin n_err++; $display("FAIL bitops_clr: got %h want AC", out_port); end
        idle(3'd0);
        n_checks++;
        if (readdata !== 32'h0000_00AC) begin n_err++; $display("FAIL bitops_read: got %h want 000000AC", readdata); end
    endtask

    task automatic test_expiry();
        int first_k;
        do_reset();
        wr(3'd6, 32'hF0);
        wr(3'd3, 32'd3);
        wr(3'd0, 32'hFF);
        first_k = 0;
        for (int k = 1; k <= 14; k++) begin
            idle(3'd5);
            if (first_k == 0 && out_port === 8'h0F) first_k = k;
            n_checks++;
            if (out_port !== m_out[7:0]) begin n_err++; $display("FAIL expiry_out_k%0d: got %h want %h", k, out_port, m_out[7:0]); end
        end
        n_checks++;
        if (first_k < 9 || first_k > 12) begin n_err++; $display("FAIL expiry_latency: got %0d want 9..12", first_k); end
        n_checks++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL expiry_irq: got %b want 1", irq); end
        n_checks++;
        if (readdata !== 32'h1) begin n_err++; $display("FAIL expiry_status_read: got %h want 1", readdata); end
        wr(3'd5, 32'h1);
        n_checks++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL w1c_irq: got %b want 0", irq); end
        n_checks++;
        if (out_port !== 8'h0F) begin n_err++; $display("FAIL w1c_out: got %h want 0F", out_port); end
    endtask

    task automatic test_kick_race();
        bit found;
        do_reset();
        wr(3'd6, 32'hF0);
        wr(3'd3, 32'd3);
        wr(3'd0, 32'hFF);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_cnt == 1 && m_ps == TD - 1) begin
                wr(3'd4, 32'h0);
                found = 1;
            end else begin
                idle(3'd0);
            end
        end
        n_checks++;
        if (!found) begin n_err++; $display("FAIL kick_race_window: got none want expiry cycle"); end
        idle(3'd4);
        n_checks++;
        if (readdata !== 32'd3) begin n_err++; $display("FAIL kick_race_count: got %0d want 3", readdata); end
        n_checks++;
        if (out_port !== 8'hFF) begin n_err++; $display("FAIL kick_race_out: got %h want FF", out_port); end
        n_checks++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL kick_race_irq: got %b want 0", irq); end
    endtask

    task automatic test_disable_reset();
        int bad_irq;
        do_reset();
        wr(3'd0, 32'hFF);
        wr(3'd6, 32'hFF);
        wr(3'd3, 32'd0);
        bad_irq = 0;
        for (int k = 0; k < 100; k++) begin
            idle(3'd4);
            if (irq !== 1'b0 || out_port !== 8'hFF) bad_irq++;
        end
        n_checks++;
        if (bad_irq != 0) begin n_err++; $display("FAIL disabled_wdt: got %0d bad cycles want 0", bad_irq); end
        wr(3'd3, 32'd2);
        idle(3'd4);
        idle(3'd4);
        n_checks++;
        if (readdata == 32'd0) begin n_err++; $display("FAIL midcount_running: got %0d want nonzero", readdata); end
        cycle(1'b0, 1'b0, 1'b1, 3'd4, 32'h0);
        n_checks++;
        if (out_port !== 8'h00 || readdata !== 32'h0 || irq !== 1'b0) begin
            n_err++; $display("FAIL midcount_reset: got out=%h rd=%h irq=%b want 00/0/0", out_port, readdata, irq);
        end
        for (int a = 3; a <= 6; a++) begin
            idle(3'(a));
            n_checks++;
            if (readdata !== 32'h0) begin n_err++; $display("FAIL reset_reg%0d: got %h want 0", a, readdata); end
        end
        bad_irq = 0;
        for (int k = 0; k < 30; k++) begin
            idle(3'd5);
            if (irq !== 1'b0) bad_irq++;
        end
        n_checks++;
        if (bad_irq != 0) begin n_err++; $display("FAIL post_reset_irq: got %0d irq cycles want 0", bad_irq); end
    endtask

    task automatic test_read_race();
        do_reset();
        wr(3'd0, 32'h55);
        wr(3'd0, 32'h3C);
        n_checks++;
        if (readdata !== 32'h55) begin n_err++; $display("FAIL rdw_old: got %h want 00000055", readdata); end
        idle(3'd0);
        n_checks++;
        if (readdata !== 32'h3C) begin n_err++; $display("FAIL rdw_new: got %h want 0000003C", readdata); end
    endtask

    task automatic test_random();
        logic        rn, cs, wn;
        logic [2:0]  a;
        logic [31:0] wd;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            rn = ($urandom_range(0, 149) != 0);
            cs = ($urandom_range(0, 3) == 0);
            wn = 1'($urandom_range(0, 1));
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd3) wd = $urandom_range(0, 3);
            if (a == 3'd5) wd = 32'($urandom_range(0, 1));
            cycle(rn, cs, wn, a, wd);
            n_checks++;
            if (out_port !== m_out[7:0]) begin n_err++; $display("FAIL rand_out_%0d: got %h want %h", k, out_port, m_out[7:0]); end
            n_checks++;
            if (irq !== m_to[0]) begin n_err++; $display("FAIL rand_irq_%0d: got %b want %b", k, irq, m_to[0]); end
            n_checks++;
            if (readdata !== m_rd) begin n_err++; $display("FAIL rand_rd_%0d: got %h want %h", k, readdata, m_rd); end
        end
    endtask

    initial begin
        m_out = 0; m_mask = 0; m_tmo = 0; m_cnt = 0; m_ps = 0; m_to = 0; m_rd = 0;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'h0;
        test_reset();
        test_bit_ops();
        test_expiry();
        test_kick_race();
        test_disable_reset();
        test_read_race();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no completion want finish");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
